// File: rtl/cherry_dma_pkg.sv
// cherry_dma_pkg: shared definitions for the DMA UART link (receive and transmit paths).
//   SYNC_BYTE    packet start marker
//   ADDR_W       destination address width
//   DATA_W       cherry float word width ({2'b00, fp16})
//   pkt_state_t  packet parser states
//   rx_state_t   byte receiver states
//   pkt_chk()    packet checksum over ADDR, HI, LO
package cherry_dma_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int         ADDR_W    = 7;
    localparam int         DATA_W    = 18;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        HI,
        LO,
        CHK
    } pkt_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    function automatic logic [7:0] pkt_chk(input logic [7:0] a,
                                           input logic [7:0] h,
                                           input logic [7:0] l);
        return a ^ h ^ l;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 byte receiver with 2-FF input synchronizer and mid-bit sampling.
//   clk         in   system clock
//   reset       in   synchronous, active-high
//   rxd         in   asynchronous UART line, idle high
//   rx_byte     out  last deserialized byte, valid while byte_valid is high
//   byte_valid  out  one-cycle pulse, stop bit sampled high
//   frame_err   out  one-cycle pulse, stop bit sampled low (byte discarded)
//   busy        out  receiver is not in RX_IDLE
//
// state    | meaning
// RX_IDLE  | line idle, waiting for a falling edge
// RX_START | half a bit into the start bit, re-check it is still low
// RX_DATA  | sampling 8 data bits LSB first, one per bit period
// RX_STOP  | waiting for the stop-bit mid sample
module uart_rx
    import cherry_dma_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int BIT_RATE = 115_200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CPB   = CLK_HZ / BIT_RATE;
    localparam int HALF  = CPB / 2;
    localparam int CNT_W = $clog2(CPB);

    rx_state_t        state;
    rx_state_t        state_nxt;
    logic             sync_1;
    logic             sync_2;
    logic             rxd_prev;
    logic [CNT_W-1:0] bit_tmr;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             tick;
    logic             start_edge;

    assign tick       = (bit_tmr == '0);
    assign start_edge = rxd_prev & ~sync_2;
    assign rx_byte    = shreg;

    always_ff @(posedge clk) begin
        if (reset) state <= RX_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RX_IDLE:  if (start_edge) state_nxt = RX_START;
            RX_START: if (tick) state_nxt = sync_2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (tick && bit_idx == 3'd7) state_nxt = RX_STOP;
            RX_STOP:  if (tick) state_nxt = RX_IDLE;
            default:  state_nxt = RX_IDLE;
        endcase
    end

    always_comb begin
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        busy       = (state != RX_IDLE);
        if (state == RX_STOP && tick) begin
            byte_valid = sync_2;
            frame_err  = ~sync_2;
        end
    end

    // Synchronizer and edge flop preset high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_1   <= 1'b1;
            sync_2   <= 1'b1;
            rxd_prev <= 1'b1;
            bit_tmr  <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
        end else begin
            sync_1   <= rxd;
            sync_2   <= sync_1;
            rxd_prev <= sync_2;
            case (state)
                RX_IDLE: begin
                    bit_tmr <= CNT_W'(HALF - 1);
                    bit_idx <= '0;
                end
                RX_START: begin
                    if (tick) bit_tmr <= CNT_W'(CPB - 1);
                    else      bit_tmr <= bit_tmr - CNT_W'(1);
                end
                RX_DATA: begin
                    if (tick) begin
                        shreg   <= {sync_2, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        bit_tmr <= CNT_W'(CPB - 1);
                    end else begin
                        bit_tmr <= bit_tmr - CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (!tick) bit_tmr <= bit_tmr - CNT_W'(1);
                end
                default: bit_tmr <= '0;
            endcase
        end
    end

endmodule

// File: rtl/dma_uart_rx.sv
// dma_uart_rx: host-to-core DMA UART receiver. Parses SYNC/ADDR/HI/LO/CHK packets
// and issues one memory write per valid packet.
//   clk           in   system clock
//   reset         in   synchronous, active-high
//   uart_rxd      in   UART receive pin, idle high
//   dma_dat_r     out  {2'b00, HI, LO} of last good packet
//   dma_dat_addr  out  address of last good packet
//   we            out  one-cycle write strobe, data/address valid with it
//   busy          out  packet or byte in progress
//   frame_err     out  one-cycle pulse, stop bit low
//   chk_err       out  one-cycle pulse, checksum mismatch or inter-byte timeout
//
// state | meaning
// IDLE  | hunting for SYNC_BYTE
// ADDR  | expecting address byte (bit7 clear); repeated SYNC resyncs here
// HI    | expecting payload high byte
// LO    | expecting payload low byte
// CHK   | expecting checksum ADDR^HI^LO
module dma_uart_rx
    import cherry_dma_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int BIT_RATE     = 115_200,
    parameter int TIMEOUT_BITS = 40
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              uart_rxd,
    output logic [DATA_W-1:0] dma_dat_r,
    output logic [ADDR_W-1:0] dma_dat_addr,
    output logic              we,
    output logic              busy,
    output logic              frame_err,
    output logic              chk_err
);

    localparam int CPB       = CLK_HZ / BIT_RATE;
    localparam int TO_CYCLES = TIMEOUT_BITS * CPB;
    localparam int TO_W      = $clog2(TO_CYCLES + 1);

    logic [7:0]        rx_byte;
    logic              byte_valid;
    logic              rx_frame_err;
    logic              rx_busy;
    pkt_state_t        state;
    pkt_state_t        state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        hi_q;
    logic [7:0]        lo_q;
    logic [TO_W-1:0]   to_tmr;
    logic              timeout;
    logic              write_ok;
    logic              chk_bad;
    logic              addr_ld;
    logic              hi_ld;
    logic              lo_ld;

    uart_rx #(
        .CLK_HZ   (CLK_HZ),
        .BIT_RATE (BIT_RATE)
    ) u_uart_rx (
        .clk        (clk),
        .reset      (reset),
        .rxd        (uart_rxd),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (rx_frame_err),
        .busy       (rx_busy)
    );

    // A byte landing in the same cycle as expiry takes priority over the timeout.
    assign timeout = (state != IDLE) && (to_tmr == '0) && !byte_valid;
    assign busy    = (state != IDLE) | rx_busy;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (rx_frame_err) begin
            state_nxt = IDLE;
        end else if (byte_valid) begin
            case (state)
                IDLE: if (rx_byte == SYNC_BYTE) state_nxt = ADDR;
                ADDR: begin
                    if (!rx_byte[7])               state_nxt = HI;
                    else if (rx_byte == SYNC_BYTE) state_nxt = ADDR;
                    else                           state_nxt = IDLE;
                end
                HI:      state_nxt = LO;
                LO:      state_nxt = CHK;
                CHK:     state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end else if (timeout) begin
            state_nxt = IDLE;
        end
    end

    always_comb begin
        write_ok = 1'b0;
        chk_bad  = timeout;
        addr_ld  = 1'b0;
        hi_ld    = 1'b0;
        lo_ld    = 1'b0;
        if (byte_valid) begin
            case (state)
                ADDR: addr_ld = ~rx_byte[7];
                HI:   hi_ld   = 1'b1;
                LO:   lo_ld   = 1'b1;
                CHK: begin
                    write_ok = (rx_byte == pkt_chk({1'b0, addr_q}, hi_q, lo_q));
                    chk_bad  = (rx_byte != pkt_chk({1'b0, addr_q}, hi_q, lo_q));
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q       <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            dma_dat_r    <= '0;
            dma_dat_addr <= '0;
            we           <= 1'b0;
            chk_err      <= 1'b0;
            frame_err    <= 1'b0;
            to_tmr       <= TO_W'(TO_CYCLES);
        end else begin
            we        <= write_ok;
            chk_err   <= chk_bad;
            frame_err <= rx_frame_err;
            if (addr_ld) addr_q <= rx_byte[ADDR_W-1:0];
            if (hi_ld)   hi_q   <= rx_byte;
            if (lo_ld)   lo_q   <= rx_byte;
            if (write_ok) begin
                dma_dat_addr <= addr_q;
                dma_dat_r    <= {2'b00, hi_q, lo_q};
            end
            // Inter-byte timer only runs between bytes of an open packet and sticks at zero.
            if (byte_valid || state == IDLE)
                to_tmr <= TO_W'(TO_CYCLES);
            else if (!rx_busy && to_tmr != '0)
                to_tmr <= to_tmr - TO_W'(1);
        end
    end

endmodule

// File: tb/tb_dma_uart_rx.sv
module tb_dma_uart_rx;

    localparam int CLK_HZ   = 50_000_000;
    localparam int BIT_RATE = 390_625;          // 128 clk per bit keeps runtime short
    localparam int CPB      = CLK_HZ / BIT_RATE;
    localparam int TO_BITS  = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        uart_rxd = 1'b1;
    logic [17:0] dma_dat_r;
    logic [6:0]  dma_dat_addr;
    logic        we;
    logic        busy;
    logic        frame_err;
    logic        chk_err;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int fe_cnt = 0;
    int ce_cnt = 0;
    logic [24:0] sb[$];

    dma_uart_rx #(
        .CLK_HZ       (CLK_HZ),
        .BIT_RATE     (BIT_RATE),
        .TIMEOUT_BITS (TO_BITS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .uart_rxd     (uart_rxd),
        .dma_dat_r    (dma_dat_r),
        .dma_dat_addr (dma_dat_addr),
        .we           (we),
        .busy         (busy),
        .frame_err    (frame_err),
        .chk_err      (chk_err)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_val, input int stop_clks);
        @(negedge clk) uart_rxd = 1'b0;
        repeat (CPB - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk) uart_rxd = b[i];
            repeat (CPB - 1) @(negedge clk);
        end
        @(negedge clk) uart_rxd = stop_val;
        repeat (stop_clks - 1) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b1, CPB);
    endtask

    task automatic idle_bits(input int n);
        @(negedge clk) uart_rxd = 1'b1;
        repeat (n * CPB - 1) @(negedge clk);
    endtask

    task automatic expect_write(input logic [6:0] a, input logic [15:0] d);
        sb.push_back({a, 2'b00, d});
    endtask

    // Scoreboard consumer: every we must match the oldest expected write.
    always @(negedge clk) begin
        if (!reset) begin
            if (frame_err) fe_cnt++;
            if (chk_err)   ce_cnt++;
            if (we) begin
                wr_cnt++;
                checks++;
                assert (sb.size() != 0)
                else begin
                    errors++;
                    $error("FAIL unexpected_we observed addr=%0d data=%0h expected no write",
                           dma_dat_addr, dma_dat_r);
                end
                if (sb.size() != 0) begin
                    logic [24:0] exp_w;
                    exp_w = sb.pop_front();
                    check("write_addr_data", {7'd0, dma_dat_addr, dma_dat_r}, {7'd0, exp_w});
                end
            end
        end
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (5) @(negedge clk);
        check("rst_we", we, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_chk_err", chk_err, 0);
        check("rst_data", dma_dat_r, 0);
        check("rst_addr", dma_dat_addr, 0);
        reset = 1'b0;
        idle_bits(2);

        // 1: good packet
        expect_write(7'd120, 16'h8555);
        send_byte(8'hA5); send_byte(8'h78); send_byte(8'h85); send_byte(8'h55); send_byte(8'hA8);
        check("t1_wr_cnt", wr_cnt, 1);
        check("t1_data", dma_dat_r, 18'd34133);
        check("t1_addr", dma_dat_addr, 7'd120);
        check("t1_ce", ce_cnt, 0);
        check("t1_fe", fe_cnt, 0);

        // 2: bad checksum, back-to-back with packet 1
        send_byte(8'hA5); send_byte(8'h78); send_byte(8'h85); send_byte(8'h55); send_byte(8'hA9);
        check("t2_ce", ce_cnt, 1);
        check("t2_wr_cnt", wr_cnt, 1);
        check("t2_data_hold", dma_dat_r, 18'd34133);
        check("t2_addr_hold", dma_dat_addr, 7'd120);

        // 3: leading junk and double sync
        expect_write(7'd5, 16'h3C00);
        send_byte(8'h13); send_byte(8'hA5); send_byte(8'hA5); send_byte(8'h05);
        send_byte(8'h3C); send_byte(8'h00); send_byte(8'h39);
        check("t3_wr_cnt", wr_cnt, 2);
        check("t3_data", dma_dat_r, 18'h03C00);
        check("t3_addr", dma_dat_addr, 7'd5);
        check("t3_ce", ce_cnt, 1);

        // 4: inter-byte timeout
        send_byte(8'hA5); send_byte(8'h78); send_byte(8'h85);
        check("t4_busy_open", busy, 1);
        idle_bits(TO_BITS + 1);
        check("t4_ce", ce_cnt, 2);
        check("t4_busy_low", busy, 0);
        send_byte(8'h55); send_byte(8'hA8);
        idle_bits(2);
        check("t4_wr_cnt", wr_cnt, 2);
        check("t4_addr_hold", dma_dat_addr, 7'd5);

        // 5: stop bit low mid-packet, then the rest of the packet is ignored
        send_byte(8'hA5);
        send_frame(8'h78, 1'b0, CPB);
        idle_bits(1);
        check("t5_fe", fe_cnt, 1);
        check("t5_busy_idle", busy, 0);
        send_byte(8'h85); send_byte(8'h55); send_byte(8'hA8);
        // short low glitch on an idle line
        @(negedge clk) uart_rxd = 1'b0;
        repeat (49) @(negedge clk);
        idle_bits(2);
        check("t5_wr_cnt", wr_cnt, 2);
        check("t5_fe_after_glitch", fe_cnt, 1);
        check("t5_ce_after_glitch", ce_cnt, 2);
        check("t5_busy_after_glitch", busy, 0);

        // 6: reset pulse during the HI byte's stop bit
        send_byte(8'hA5); send_byte(8'h78);
        send_frame(8'h85, 1'b1, 10);
        reset = 1'b1;
        @(negedge clk);
        check("t6_rst_data", dma_dat_r, 0);
        check("t6_rst_addr", dma_dat_addr, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_we", we, 0);
        reset = 1'b0;
        idle_bits(3);
        check("t6_ce_none", ce_cnt, 2);
        check("t6_fe_none", fe_cnt, 1);
        expect_write(7'd10, 16'h1234);
        send_byte(8'hA5); send_byte(8'h0A); send_byte(8'h12); send_byte(8'h34); send_byte(8'h2C);
        check("t6_wr_cnt", wr_cnt, 3);
        check("t6_data", dma_dat_r, 18'h01234);
        check("t6_addr", dma_dat_addr, 7'd10);

        // 7: two zero-gap packets at address/data extremes
        expect_write(7'd1, 16'h0001);
        expect_write(7'd127, 16'hFFFF);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
        check("t7a_addr", dma_dat_addr, 7'd1);
        send_byte(8'hA5); send_byte(8'h7F); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h7F);
        idle_bits(1);
        check("t7_wr_cnt", wr_cnt, 5);
        check("t7_data", dma_dat_r, 18'h0FFFF);
        check("t7_addr", dma_dat_addr, 7'd127);
        check("t7_ce", ce_cnt, 2);
        check("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
